// File: rtl/display_digit_sequencer.sv
// -----------------------------------------------------------------------------
// display_digit_sequencer
//
// Samples BCD display data and a 2-bit mode select at a throttled update rate,
// holds both, and drives per-display decimal-point and leading-zero blanking
// masks for an N_DIGITS seven-segment bank. It sits between the mode/data mux
// and the seven-segment drivers.
//
// Optional feature macro: DISPLAY_BLINK_EN
//   defined   -> alarm blinking. While alarm is high, the bank alternates
//                between normal masks and fully dark every BLINK_TICKS clocks.
//   undefined -> no blink logic. The alarm input is ignored and the masks
//                depend only on the held values.
//
// Ports
//   clk            in   1         system clock, all state on rising edge
//   reset          in   1         synchronous, active-high
//   data           in   4*N_BCD   BCD digits, digit 0 in [3:0]
//   select         in   2         display mode 0..3
//   alarm          in   1         blink request (level)
//   data_out       out  4*N_BCD   held data
//   DP             out  N_DIGITS  decimal-point enables, 1 = lit
//   Blank          out  N_DIGITS  blank enables, 1 = display off
//   update_strobe  out  1         one-cycle pulse, held registers refreshed
//
// Timing
//   - After reset, the first clock edge is always an update, because the
//     pending flag is set.
//   - DP and Blank are registered from the held values. They therefore lag
//     update_strobe and data_out by one edge.
// -----------------------------------------------------------------------------
module display_digit_sequencer #(
  parameter int N_DIGITS     = 6,
  parameter int N_BCD        = 4,
  parameter int DP_POS_0     = 6,
  parameter int DP_POS_1     = 6,
  parameter int DP_POS_2     = 2,
  parameter int DP_POS_3     = 3,
  parameter int MIN_DIG_0    = 4,
  parameter int MIN_DIG_1    = 1,
  parameter int MIN_DIG_2    = 3,
  parameter int MIN_DIG_3    = 4,
  parameter int UPDATE_TICKS = 5_000_000,
  parameter int BLINK_TICKS  = 12_500_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_BCD-1:0]    data,
  input  logic [1:0]            select,
  input  logic                  alarm,
  output logic [4*N_BCD-1:0]    data_out,
  output logic [N_DIGITS-1:0]   DP,
  output logic [N_DIGITS-1:0]   Blank,
  output logic                  update_strobe
);

  localparam int UPD_W = $clog2(UPDATE_TICKS);
  localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(UPDATE_TICKS - 1);

  // ---------------------------------------------------------------------------
  // Per-mode constant lookups
  // ---------------------------------------------------------------------------
  function automatic int dp_pos_f(input logic [1:0] sel);
    case (sel)
      2'd0:    return DP_POS_0;
      2'd1:    return DP_POS_1;
      2'd2:    return DP_POS_2;
      2'd3:    return DP_POS_3;
      default: return DP_POS_0;
    endcase
  endfunction

  function automatic int min_dig_f(input logic [1:0] sel);
    case (sel)
      2'd0:    return MIN_DIG_0;
      2'd1:    return MIN_DIG_1;
      2'd2:    return MIN_DIG_2;
      2'd3:    return MIN_DIG_3;
      default: return MIN_DIG_0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Update path state
  // ---------------------------------------------------------------------------
  logic [UPD_W-1:0]    upd_cnt_q,   upd_cnt_d;
  logic [4*N_BCD-1:0]  held_data_q, held_data_d;
  logic [1:0]          held_sel_q,  held_sel_d;
  logic                pending_q;
  logic                strobe_q;
  logic                update_evt_s;

  // ---------------------------------------------------------------------------
  // Mask path state
  // ---------------------------------------------------------------------------
  logic [N_DIGITS-1:0] dp_q,    blank_q;
  logic [N_DIGITS-1:0] dp_s,    blank_s;
  int                  sig_s;
  int                  shown_s;
  int                  min_dig_s;
  int                  dp_pos_s;
  logic                phase_s;    // 1 = on (normal masks), 0 = forced dark

  // Update event decode and next values for the held registers.
  // Several trigger conditions may be true at once; they still form one
  // event, because they all collapse into the same single strobe.
  always_comb begin
    update_evt_s = (upd_cnt_q == UPD_LAST) || (select != held_sel_q) || pending_q;
    upd_cnt_d    = upd_cnt_q;
    held_data_d  = held_data_q;
    held_sel_d   = held_sel_q;
    if (update_evt_s) begin
      upd_cnt_d   = '0;
      held_data_d = data;
      held_sel_d  = select;
    end else begin
      upd_cnt_d   = upd_cnt_q + UPD_W'(1);
      held_data_d = held_data_q;
      held_sel_d  = held_sel_q;
    end
  end

  // Update path registers: period counter, held data/select, pending, strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_cnt_q   <= '0;
      held_data_q <= '0;
      held_sel_q  <= 2'd0;
      pending_q   <= 1'b1;
      strobe_q    <= 1'b0;
    end else begin
      upd_cnt_q   <= upd_cnt_d;
      held_data_q <= held_data_d;
      held_sel_q  <= held_sel_d;
      // Any pending request is consumed by the event it forces on this edge.
      pending_q   <= 1'b0;
      strobe_q    <= update_evt_s;
    end
  end

  // Leading-zero blanking and decimal-point decode from the held values.
  // Non-decimal nibbles (A-F) count as significant digits; no error is raised.
  always_comb begin
    sig_s     = 0;
    min_dig_s = min_dig_f(held_sel_q);
    dp_pos_s  = dp_pos_f(held_sel_q);
    shown_s   = 0;
    blank_s   = '0;
    dp_s      = '0;
    // Scan upward so the last nonzero nibble found is the most significant.
    for (int i = 0; i < N_BCD; i++) begin
      if (held_data_q[4*i +: 4] != 4'd0) begin
        sig_s = i + 1;
      end else begin
        sig_s = sig_s;
      end
    end
    if (sig_s > min_dig_s) begin
      shown_s = sig_s;
    end else begin
      shown_s = min_dig_s;
    end
    // Positions past the BCD field never carry a digit, so they stay dark.
    if (shown_s > N_BCD) begin
      shown_s = N_BCD;
    end else begin
      shown_s = shown_s;
    end
    // A DP position at or beyond N_DIGITS simply matches no display.
    for (int i = 0; i < N_DIGITS; i++) begin
      blank_s[i] = (i >= shown_s);
      dp_s[i]    = (i == dp_pos_s);
    end
  end

`ifdef DISPLAY_BLINK_EN
  // ---------------------------------------------------------------------------
  // Alarm blink: half-period counter and on/off phase
  // ---------------------------------------------------------------------------
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             phase_q,   phase_d;

  // Blink next-state: idle on while alarm is low, otherwise toggle each half-period.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    phase_d   = phase_q;
    if (!alarm) begin
      blk_cnt_d = '0;
      phase_d   = 1'b1;
    end else if (blk_cnt_q == BLK_LAST) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end else begin
      blk_cnt_d = blk_cnt_q + BLK_W'(1);
      phase_d   = phase_q;
    end
  end

  // Blink registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt_q <= '0;
      phase_q   <= 1'b1;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign phase_s = phase_q;
`else
  // Without blink support the bank is permanently in the on phase. The alarm
  // input is kept for port compatibility, and its value is intentionally
  // discarded here.
  logic alarm_unused_s;
  assign alarm_unused_s = alarm;
  assign phase_s        = 1'b1;
`endif

  // Output mask registers, refreshed every cycle. The off phase forces the
  // whole bank dark and all DPs off.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_q    <= '0;
      blank_q <= '1;
    end else if (phase_s) begin
      dp_q    <= dp_s;
      blank_q <= blank_s;
    end else begin
      dp_q    <= '0;
      blank_q <= '1;
    end
  end

  assign data_out      = held_data_q;
  assign DP            = dp_q;
  assign Blank         = blank_q;
  assign update_strobe = strobe_q;

endmodule

// File: tb/tb_display_digit_sequencer.sv
// Directed bench for display_digit_sequencer with UPDATE_TICKS=8, BLINK_TICKS=4.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at
// the same point, so each check sees the state produced by the preceding edge.
module tb_display_digit_sequencer;

`ifdef DISPLAY_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] data;
  logic [1:0]  select;
  logic        alarm;
  logic [15:0] data_out;
  logic [5:0]  DP;
  logic [5:0]  Blank;
  logic        update_strobe;

  int n_chk;
  int n_pass;

  display_digit_sequencer #(
    .UPDATE_TICKS (8),
    .BLINK_TICKS  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data          (data),
    .select        (select),
    .alarm         (alarm),
    .data_out      (data_out),
    .DP            (DP),
    .Blank         (Blank),
    .update_strobe (update_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset state, then the forced first update and the first valid masks.
  task automatic test_reset();
    reset = 1'b1; select = 2'd0; data = 16'h0000; alarm = 1'b0;
    tick(); tick();
    n_chk++; if (Blank !== 6'b111111) $display("FAIL rst_blank got %b want %b", Blank, 6'b111111); else n_pass++;
    n_chk++; if (DP !== 6'b000000) $display("FAIL rst_dp got %b want %b", DP, 6'b000000); else n_pass++;
    n_chk++; if (update_strobe !== 1'b0) $display("FAIL rst_strobe got %b want 0", update_strobe); else n_pass++;
    n_chk++; if (data_out !== 16'h0000) $display("FAIL rst_data got %h want 0000", data_out); else n_pass++;
    reset = 1'b0;
    tick();
    n_chk++; if (update_strobe !== 1'b1) $display("FAIL first_strobe got %b want 1", update_strobe); else n_pass++;
    tick();
    n_chk++; if (update_strobe !== 1'b0) $display("FAIL first_strobe_end got %b want 0", update_strobe); else n_pass++;
    n_chk++; if (Blank !== 6'b110000) $display("FAIL first_blank got %b want %b", Blank, 6'b110000); else n_pass++;
    n_chk++; if (DP !== 6'b000000) $display("FAIL first_dp got %b want %b", DP, 6'b000000); else n_pass++;
  endtask

  // Periodic update. A data change alone must wait for the next periodic strobe.
  task automatic test_periodic();
    select = 2'd1; data = 16'h005A;
    tick();
    n_chk++; if (update_strobe !== 1'b1) $display("FAIL per_sel_strobe got %b want 1", update_strobe); else n_pass++;
    n_chk++; if (data_out !== 16'h005A) $display("FAIL per_data got %h want 005a", data_out); else n_pass++;
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_chk++; if (update_strobe !== 1'b0) $display("FAIL per_quiet_strobe cyc %0d got %b want 0", i, update_strobe); else n_pass++;
      n_chk++; if (Blank !== 6'b111100) $display("FAIL per_blank cyc %0d got %b want %b", i, Blank, 6'b111100); else n_pass++;
      n_chk++; if (data_out !== 16'h005A) $display("FAIL per_hold cyc %0d got %h want 005a", i, data_out); else n_pass++;
      if (i == 2) data = 16'h0000;
    end
    tick();
    n_chk++; if (update_strobe !== 1'b1) $display("FAIL per_strobe8 got %b want 1", update_strobe); else n_pass++;
    n_chk++; if (data_out !== 16'h0000) $display("FAIL per_data2 got %h want 0000", data_out); else n_pass++;
    tick();
    n_chk++; if (Blank !== 6'b111110) $display("FAIL per_blank2 got %b want %b", Blank, 6'b111110); else n_pass++;
    n_chk++; if (DP !== 6'b000000) $display("FAIL per_dp2 got %b want %b", DP, 6'b000000); else n_pass++;
  endtask

  // A mid-period select change updates immediately and restarts the period.
  task automatic test_select_change();
    tick(); tick();
    select = 2'd2; data = 16'h0165;
    tick();
    n_chk++; if (update_strobe !== 1'b1) $display("FAIL sel_strobe got %b want 1", update_strobe); else n_pass++;
    n_chk++; if (data_out !== 16'h0165) $display("FAIL sel_data got %h want 0165", data_out); else n_pass++;
    tick();
    n_chk++; if (Blank !== 6'b111000) $display("FAIL sel_blank got %b want %b", Blank, 6'b111000); else n_pass++;
    n_chk++; if (DP !== 6'b000100) $display("FAIL sel_dp got %b want %b", DP, 6'b000100); else n_pass++;
    for (int i = 2; i <= 7; i++) begin
      tick();
      n_chk++; if (update_strobe !== 1'b0) $display("FAIL sel_quiet cyc %0d got %b want 0", i, update_strobe); else n_pass++;
    end
    tick();
    n_chk++; if (update_strobe !== 1'b1) $display("FAIL sel_restart got %b want 1", update_strobe); else n_pass++;
  endtask

  // Mode 3 minimum-width behaviour and a non-decimal digit counted as significant.
  task automatic test_modes();
    bit got;
    select = 2'd3; data = 16'h5151;
    tick(); tick();
    n_chk++; if (Blank !== 6'b110000) $display("FAIL m3_blank got %b want %b", Blank, 6'b110000); else n_pass++;
    n_chk++; if (DP !== 6'b001000) $display("FAIL m3_dp got %b want %b", DP, 6'b001000); else n_pass++;
    data = 16'h0000;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (update_strobe === 1'b1) got = 1'b1;
    end
    n_chk++; if (got !== 1'b1) $display("FAIL m3_wait_strobe got %b want 1", got); else n_pass++;
    tick();
    n_chk++; if (data_out !== 16'h0000) $display("FAIL m3z_data got %h want 0000", data_out); else n_pass++;
    n_chk++; if (Blank !== 6'b110000) $display("FAIL m3z_blank got %b want %b", Blank, 6'b110000); else n_pass++;
    n_chk++; if (DP !== 6'b001000) $display("FAIL m3z_dp got %b want %b", DP, 6'b001000); else n_pass++;
    select = 2'd1; data = 16'h0B00;
    tick(); tick();
    n_chk++; if (Blank !== 6'b111000) $display("FAIL hex_blank got %b want %b", Blank, 6'b111000); else n_pass++;
    n_chk++; if (DP !== 6'b000000) $display("FAIL hex_dp got %b want %b", DP, 6'b000000); else n_pass++;
  endtask

  // Alarm blinking: four edges normal and four dark, then recovery after deassert.
  task automatic test_blink();
    logic [5:0] exp_blank;
    logic [5:0] exp_dp;
    bit         off;
    select = 2'd2; data = 16'h0165;
    tick(); tick();
    alarm = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      off = BLINK_EN && ((i >= 5 && i <= 8) || i >= 13);
      exp_blank = off ? 6'b111111 : 6'b111000;
      exp_dp    = off ? 6'b000000 : 6'b000100;
      n_chk++; if (Blank !== exp_blank) $display("FAIL blink_blank edge %0d got %b want %b", i, Blank, exp_blank); else n_pass++;
      n_chk++; if (DP !== exp_dp) $display("FAIL blink_dp edge %0d got %b want %b", i, DP, exp_dp); else n_pass++;
    end
    alarm = 1'b0;
    tick();
    exp_blank = BLINK_EN ? 6'b111111 : 6'b111000;
    n_chk++; if (Blank !== exp_blank) $display("FAIL unblink1_blank got %b want %b", Blank, exp_blank); else n_pass++;
    tick();
    n_chk++; if (Blank !== 6'b111000) $display("FAIL unblink2_blank got %b want %b", Blank, 6'b111000); else n_pass++;
    n_chk++; if (DP !== 6'b000100) $display("FAIL unblink2_dp got %b want %b", DP, 6'b000100); else n_pass++;
  endtask

  // Reset during the dark phase, mid-count, then a clean restart.
  task automatic test_reset_mid();
    logic [5:0] exp_blank;
    alarm = 1'b1;
    for (int i = 1; i <= 6; i++) tick();
    exp_blank = BLINK_EN ? 6'b111111 : 6'b111000;
    n_chk++; if (Blank !== exp_blank) $display("FAIL pre_rst_blank got %b want %b", Blank, exp_blank); else n_pass++;
    reset = 1'b1;
    tick();
    n_chk++; if (Blank !== 6'b111111) $display("FAIL mrst_blank got %b want %b", Blank, 6'b111111); else n_pass++;
    n_chk++; if (DP !== 6'b000000) $display("FAIL mrst_dp got %b want %b", DP, 6'b000000); else n_pass++;
    n_chk++; if (update_strobe !== 1'b0) $display("FAIL mrst_strobe got %b want 0", update_strobe); else n_pass++;
    n_chk++; if (data_out !== 16'h0000) $display("FAIL mrst_data got %h want 0000", data_out); else n_pass++;
    reset = 1'b0; alarm = 1'b0;
    tick();
    n_chk++; if (update_strobe !== 1'b1) $display("FAIL post_rst_strobe got %b want 1", update_strobe); else n_pass++;
    n_chk++; if (data_out !== 16'h0165) $display("FAIL post_rst_data got %h want 0165", data_out); else n_pass++;
    tick();
    n_chk++; if (Blank !== 6'b111000) $display("FAIL post_rst_blank got %b want %b", Blank, 6'b111000); else n_pass++;
    n_chk++; if (DP !== 6'b000100) $display("FAIL post_rst_dp got %b want %b", DP, 6'b000100); else n_pass++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b1; data = 16'h0000; select = 2'd0; alarm = 1'b0;
    test_reset();
    test_periodic();
    test_select_change();
    test_modes();
    test_blink();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
